// File: rtl/user_io_timer_array_if.sv
// Host-side bus of the timer array: configuration write port and count read port.
// Handshake: cfg_we is a one-cycle write strobe that is always accepted (no ready);
// rd_req is sampled on a clock edge and answered by exactly one rd_valid pulse on
// the following cycle, with rd_data valid only while rd_valid is high. There is no
// backpressure in either direction, so requests may be issued every cycle.
interface user_io_timer_array_if #(
    parameter int W   = 16,
    parameter int CHW = 5
);
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_field;
    logic [W-1:0]   cfg_data;
    logic           rd_req;
    logic [CHW-1:0] rd_ch;
    logic           rd_valid;
    logic [W-1:0]   rd_data;

    modport master (
        output cfg_we, cfg_ch, cfg_field, cfg_data, rd_req, rd_ch,
        input  rd_valid, rd_data
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_field, cfg_data, rd_req, rd_ch,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/user_io_timer_array.sv
// Multi-channel io timer array. Each channel is independently OFF, clock
// divider, PWM generator or synchronised rising-edge counter. Period and duty
// are double-buffered (shadow -> active) so a running waveform only changes
// at a counter wrap.
module user_io_timer_array #(
    parameter int NCH = 16,
    parameter int W   = 16,
    parameter int CHW = 5
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    user_io_timer_array_if.slave    bus,
    input  logic [NCH-1:0]          io_in,
    output logic [NCH-1:0]          io_out,
    output logic [NCH-1:0]          io_oeb
);
    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_PWM  = 2'd2;
    localparam logic [1:0] MODE_EDGE = 2'd3;

    localparam logic [1:0] FIELD_MODE   = 2'd0;
    localparam logic [1:0] FIELD_PERIOD = 2'd1;
    localparam logic [1:0] FIELD_DUTY   = 2'd2;
    localparam logic [1:0] FIELD_CLEAR  = 2'd3;

    logic [W-1:0] cnt_w [NCH];
    logic [W-1:0] rd_sel;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]   mode_q;
        logic [W-1:0] cnt_q;
        logic [W-1:0] per_sh_q;
        logic [W-1:0] duty_sh_q;
        logic [W-1:0] per_act_q;
        logic [W-1:0] duty_act_q;
        logic         out_q;
        logic         sync1_q;
        logic         sync2_q;
        logic         edge_q;
        logic         hit;
        logic         mode_wr;
        logic         per_wr;
        logic         duty_wr;
        logic         clr_wr;
        logic         run;
        logic         wrap;
        logic         rise;

        // Out-of-range channel numbers never match any i, so such writes are dropped.
        assign hit     = bus.cfg_we && (bus.cfg_ch == CHW'(i));
        assign mode_wr = hit && (bus.cfg_field == FIELD_MODE);
        assign per_wr  = hit && (bus.cfg_field == FIELD_PERIOD);
        assign duty_wr = hit && (bus.cfg_field == FIELD_DUTY);
        assign clr_wr  = hit && (bus.cfg_field == FIELD_CLEAR);
        assign run     = (mode_q == MODE_DIV) || (mode_q == MODE_PWM);
        assign wrap    = run && (cnt_q == per_act_q);
        assign rise    = sync2_q && !edge_q;

        // Channel state: synchroniser, shadow/active registers, counter and output.
        always_ff @(posedge wb_clk_i) begin
            if (!wb_rst_ni) begin
                mode_q     <= MODE_OFF;
                cnt_q      <= '0;
                per_sh_q   <= '0;
                duty_sh_q  <= '0;
                per_act_q  <= '0;
                duty_act_q <= '0;
                out_q      <= 1'b0;
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                edge_q     <= 1'b0;
            end else begin
                sync1_q <= io_in[i];
                sync2_q <= sync1_q;
                edge_q  <= sync2_q;
                if (per_wr) begin
                    per_sh_q <= bus.cfg_data;
                end
                if (duty_wr) begin
                    duty_sh_q <= bus.cfg_data;
                end
                if (mode_wr) begin
                    mode_q     <= bus.cfg_data[1:0];
                    cnt_q      <= '0;
                    out_q      <= 1'b0;
                    per_act_q  <= per_sh_q;
                    duty_act_q <= duty_sh_q;
                end else begin
                    // Idle channels track the shadow immediately; running ones only at wrap,
                    // where a same-cycle write lands in the shadow and waits for the next wrap.
                    if (!run) begin
                        per_act_q  <= per_wr  ? bus.cfg_data : per_sh_q;
                        duty_act_q <= duty_wr ? bus.cfg_data : duty_sh_q;
                    end else if (wrap) begin
                        per_act_q  <= per_sh_q;
                        duty_act_q <= duty_sh_q;
                    end
                    case (mode_q)
                        MODE_DIV: begin
                            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
                            if (wrap) begin
                                out_q <= !out_q;
                            end
                        end
                        MODE_PWM: begin
                            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
                            out_q <= (cnt_q < duty_act_q);
                        end
                        MODE_EDGE: begin
                            if (rise) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                            out_q <= 1'b0;
                        end
                        default: begin
                            out_q <= 1'b0;
                        end
                    endcase
                    if (clr_wr) begin
                        cnt_q <= '0;
                    end
                end
            end
        end

        assign io_out[i] = run && out_q;
        assign io_oeb[i] = !run;
        assign cnt_w[i]  = cnt_q;
    end

    // Read mux; channel numbers beyond NCH select nothing and read back zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.rd_ch == CHW'(i)) begin
                rd_sel = cnt_w[i];
            end
        end
    end

    // Read response: one-cycle valid pulse, data held between reads.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                bus.rd_data <= rd_sel;
            end
        end
    end
endmodule

// File: tb/tb_user_io_timer_array.sv
// Self-checking bench for user_io_timer_array: a 16-channel/16-bit instance and a
// 4-channel/4-bit instance for counter wrap. Read responses are scored from
// expected queues; pad outputs are compared against waveform rules each cycle.
module tb_user_io_timer_array;
    localparam int NCH  = 16;
    localparam int W    = 16;
    localparam int CHW  = 5;
    localparam int NCH2 = 4;
    localparam int W2   = 4;
    localparam int CHW2 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    user_io_timer_array_if #(.W(W),  .CHW(CHW))  bus ();
    user_io_timer_array_if #(.W(W2), .CHW(CHW2)) bus2 ();

    logic [NCH-1:0]  io_in, io_out, io_oeb;
    logic [NCH2-1:0] io_in2, io_out2, io_oeb2;

    user_io_timer_array #(.NCH(NCH), .W(W), .CHW(CHW)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    user_io_timer_array #(.NCH(NCH2), .W(W2), .CHW(CHW2)) dut2 (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus2),
        .io_in    (io_in2),
        .io_out   (io_out2),
        .io_oeb   (io_oeb2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_q[$];
    logic [W2-1:0] exp_q2[$];
    int unsigned   model_cnt[NCH];
    int unsigned   model_cnt2[NCH2];
    logic [W-1:0]  e1;
    logic [W2-1:0] e2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: pop one expected count per read response.
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e1 = exp_q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(e1));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus2.rd_valid) begin
            if (exp_q2.size() == 0) begin
                check("rd2_unexpected", 32'd1, 32'd0);
            end else begin
                e2 = exp_q2.pop_front();
                check("rd2_data", 32'(bus2.rd_data), 32'(e2));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    // PWM output rule: out(k) reflects count(k-1) < duty in force at cycle k-1; a
    // duty written in cycle wk is in force only after a later wrap (count==p).
    function automatic logic pwm_exp(input int k, input int p, input int d0, input int d1, input int wk);
        int  j;
        bit  sw;
        if (k == 0) return 1'b0;
        j  = k - 1;
        sw = 1'b0;
        if (wk >= 0) begin
            for (int m = wk + 1; m < j; m++) begin
                if (m % (p + 1) == p) sw = 1'b1;
            end
        end
        return ((j % (p + 1)) < (sw ? d1 : d0));
    endfunction

    task automatic cfg_wr(input int ch, input int field, input int data);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = CHW'(ch);
        bus.cfg_field = 2'(field);
        bus.cfg_data  = W'(data);
        if (ch < NCH && (field == 0 || field == 3)) model_cnt[ch] = 0;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_wr2(input int ch, input int field, input int data);
        @(negedge clk);
        bus2.cfg_we    = 1'b1;
        bus2.cfg_ch    = CHW2'(ch);
        bus2.cfg_field = 2'(field);
        bus2.cfg_data  = W2'(data);
        if (field == 0 || field == 3) model_cnt2[ch] = 0;
        @(negedge clk);
        bus2.cfg_we = 1'b0;
    endtask

    task automatic rd(input int ch);
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_ch  = CHW'(ch);
        if (ch < NCH) exp_q.push_back(W'(model_cnt[ch]));
        else          exp_q.push_back('0);
        @(negedge clk);
        bus.rd_req = 1'b0;
    endtask

    task automatic rd2(input int ch);
        @(negedge clk);
        bus2.rd_req = 1'b1;
        bus2.rd_ch  = CHW2'(ch);
        exp_q2.push_back(W2'(model_cnt2[ch]));
        @(negedge clk);
        bus2.rd_req = 1'b0;
    endtask

    // Two-cycle high pulse followed by a random low gap long enough to resynchronise.
    task automatic pulse(input bit which, input int ch);
        @(negedge clk);
        if (which) io_in2[ch] = 1'b1; else io_in[ch] = 1'b1;
        repeat (2) @(negedge clk);
        if (which) io_in2[ch] = 1'b0; else io_in[ch] = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        if (which) model_cnt2[ch]++; else model_cnt[ch]++;
    endtask

    initial begin
        int p, d, n, ch;
        for (int i = 0; i < NCH; i++)  model_cnt[i]  = 0;
        for (int i = 0; i < NCH2; i++) model_cnt2[i] = 0;
        bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_field = '0; bus.cfg_data = '0;
        bus.rd_req = 0; bus.rd_ch = '0;
        bus2.cfg_we = 0; bus2.cfg_ch = '0; bus2.cfg_field = '0; bus2.cfg_data = '0;
        bus2.rd_req = 0; bus2.rd_ch = '0;
        io_in = '0; io_in2 = '0;

        // Reset held while the host and pads thrash.
        @(posedge clk);
        repeat (8) begin
            @(negedge clk);
            check("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
            check("rst_out", 32'(io_out), 32'h0);
            check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
            check("rst_oeb2", 32'(io_oeb2), 32'hF);
            bus.cfg_we = 1'($urandom_range(0, 1)); bus.cfg_ch = CHW'($urandom);
            bus.cfg_field = 2'($urandom); bus.cfg_data = W'($urandom);
            bus.rd_req = 1'($urandom_range(0, 1)); bus.rd_ch = CHW'($urandom);
            io_in = NCH'($urandom);
        end
        @(negedge clk);
        bus.cfg_we = 0; bus.rd_req = 0; io_in = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rd_data", 32'(bus.rd_data), 32'h0);
        check("post_rst_oeb", 32'(io_oeb), 32'h0000_FFFF);

        // Divider, period 4: output toggles every 5 cycles.
        cfg_wr(0, 1, 4);
        cfg_wr(0, 0, 1);
        for (int k = 0; k < 25; k++) begin
            if (k > 0) @(negedge clk);
            check("div0_out", 32'(io_out[0]), 32'((k / 5) % 2));
        end
        check("div0_oeb", 32'(io_oeb[0]), 32'h0);

        // Divider with random period on ch1.
        p = $urandom_range(0, 6);
        cfg_wr(1, 1, p);
        cfg_wr(1, 0, 1);
        for (int k = 0; k < 4 * (p + 1) + 3; k++) begin
            if (k > 0) @(negedge clk);
            check("div1_out", 32'(io_out[1]), 32'((k / (p + 1)) % 2));
        end

        // PWM period 9 duty 3, duty 7 written mid-period.
        cfg_wr(3, 1, 9);
        cfg_wr(3, 2, 3);
        cfg_wr(3, 0, 2);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            check("pwm_dchg", 32'(io_out[3]), 32'(pwm_exp(k, 9, 3, 7, 4)));
            if (k == 4) begin
                bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(3); bus.cfg_field = 2'd2; bus.cfg_data = W'(7);
            end else begin
                bus.cfg_we = 1'b0;
            end
        end
        check("pwm_oeb", 32'(io_oeb[3]), 32'h0);

        // Duty 0 is constant low, duty above period is constant high.
        cfg_wr(3, 2, 0);
        cfg_wr(3, 0, 2);
        for (int k = 0; k < 22; k++) begin
            if (k > 0) @(negedge clk);
            check("pwm_d0", 32'(io_out[3]), 32'(pwm_exp(k, 9, 0, 0, -1)));
        end
        cfg_wr(3, 2, 12);
        cfg_wr(3, 0, 2);
        for (int k = 0; k < 22; k++) begin
            if (k > 0) @(negedge clk);
            check("pwm_d12", 32'(io_out[3]), 32'(pwm_exp(k, 9, 12, 12, -1)));
        end

        // Random PWM on ch4.
        p = $urandom_range(1, 7);
        d = $urandom_range(0, p + 2);
        cfg_wr(4, 1, p);
        cfg_wr(4, 2, d);
        cfg_wr(4, 0, 2);
        for (int k = 0; k < 3 * (p + 1) + 2; k++) begin
            if (k > 0) @(negedge clk);
            check("pwm4_out", 32'(io_out[4]), 32'(pwm_exp(k, p, d, d, -1)));
        end

        // Edge counter on ch5: six pulses, then same-cycle clear and read.
        cfg_wr(5, 0, 3);
        check("edge_oeb", 32'(io_oeb[5]), 32'h1);
        repeat (6) pulse(1'b0, 5);
        repeat (3) @(negedge clk);
        check("edge_out", 32'(io_out[5]), 32'h0);
        rd(5);
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_ch = CHW'(5);
        bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(5); bus.cfg_field = 2'd3; bus.cfg_data = '0;
        exp_q.push_back(W'(model_cnt[5]));
        model_cnt[5] = 0;
        @(negedge clk);
        bus.rd_req = 1'b0; bus.cfg_we = 1'b0;
        rd(5);

        // Random interleaved edges on ch7 and ch9.
        cfg_wr(7, 0, 3);
        cfg_wr(9, 0, 3);
        pulse(1'b0, 7);
        n = $urandom_range(5, 15);
        repeat (n) begin
            ch = ($urandom_range(0, 1) == 0) ? 7 : 9;
            pulse(1'b0, ch);
        end
        repeat (3) @(negedge clk);
        rd(7);
        rd(9);

        // Out-of-range channels: no state change, read returns zero.
        cfg_wr(0, 0, 0);
        cfg_wr(1, 0, 0);
        cfg_wr(3, 0, 0);
        cfg_wr(4, 0, 0);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(NCH); bus.cfg_field = 2'd0; bus.cfg_data = W'(1);
        bus.rd_req = 1'b1; bus.rd_ch = CHW'(NCH);
        exp_q.push_back('0);
        @(negedge clk);
        bus.cfg_ch = CHW'(23); bus.cfg_field = 2'd3;
        bus.rd_req = 1'b1; bus.rd_ch = CHW'(23);
        exp_q.push_back('0);
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check("oor_oeb", 32'(io_oeb), 32'h0000_FFFF);
        check("oor_out", 32'(io_out), 32'h0);
        rd(7);

        // Narrow counter: 17 edges wrap a 4-bit count to 1, then random count.
        cfg_wr2(1, 0, 3);
        repeat (17) pulse(1'b1, 1);
        repeat (3) @(negedge clk);
        rd2(1);
        cfg_wr2(1, 3, 0);
        n = $urandom_range(1, 40);
        repeat (n) pulse(1'b1, 1);
        repeat (3) @(negedge clk);
        rd2(1);

        repeat (5) @(negedge clk);
        check("sb_drain", 32'(exp_q.size() + exp_q2.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
